// File: rtl/loader_pkg.sv
// loader_pkg: frame FSM and UART receiver state encodings plus the frame header byte.
package loader_pkg;
    localparam logic [7:0] LOADER_HEADER = 8'hA5;
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CSUM, DONE} loader_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
endpackage

// File: rtl/prog_loader_uartrx.sv
// uartrx: 8N1 UART receiver with 2-flop synchronizer, mid-bit sampling and glitch rejection.
module uartrx
    import loader_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1250
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             rx,
    output logic [WIDTH-1:0] rx_byte,
    output logic             rx_valid,
    output logic             rx_ferr
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(WIDTH);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    rx_state_t     state;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bit_idx;
    logic          rx_s;

    assign rx_s = sync[1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync     <= 2'b11;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            sync     <= {sync[0], rx};
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            cnt      <= cnt + 1'b1;
            case (state)
                RX_IDLE: if (!rx_s) begin
                    state <= RX_START;
                    cnt   <= CW'(1);
                end
                // a start bit that is high again at mid-bit was only a glitch
                RX_START: if (cnt == HALF) begin
                    state   <= rx_s ? RX_IDLE : RX_DATA;
                    cnt     <= CW'(1);
                    bit_idx <= '0;
                end
                RX_DATA: if (cnt == FULL) begin
                    rx_byte <= {rx_s, rx_byte[WIDTH-1:1]};
                    cnt     <= CW'(1);
                    bit_idx <= bit_idx + 1'b1;
                    if (bit_idx == BW'(WIDTH - 1)) state <= RX_STOP;
                end
                RX_STOP: if (cnt == FULL) begin
                    rx_valid <= rx_s;
                    rx_ferr  <= !rx_s;
                    state    <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: UART program loader that fills CPU RAM and holds the CPU in reset until an image lands.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing checksum byte before committing an image.
module prog_loader
    import loader_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int CLKS_PER_BIT  = 1250
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx,
    output logic                     wr_en,
    output logic [ADDRESS_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]         wr_data,
    output logic                     cpu_rstn,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);
    localparam int DEPTH = 1 << ADDRESS_WIDTH;
    localparam int NW    = ADDRESS_WIDTH + 1;

    loader_state_t            state;
    logic [WIDTH-1:0]         rx_byte;
    logic                     rx_valid;
    logic                     rx_ferr;
    logic [NW-1:0]            left;
    logic [ADDRESS_WIDTH-1:0] addr;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0]         sum;
`endif

    uartrx #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign busy = (state == COUNT) || (state == DATA) || (state == CSUM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            left     <= '0;
            addr     <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            cpu_rstn <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (rx_ferr && busy) begin
                err   <= 1'b1;
                state <= IDLE;
            end else if (rx_valid) begin
                case (state)
                    IDLE, DONE: if (rx_byte == WIDTH'(LOADER_HEADER)) begin
                        state    <= COUNT;
                        err      <= 1'b0;
                        done     <= 1'b0;
                        cpu_rstn <= 1'b0;
                    end
                    // a count of zero stands for a full-depth image
                    COUNT: if (32'(rx_byte) > DEPTH) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        left  <= (rx_byte == '0) ? NW'(DEPTH) : NW'(rx_byte);
                        addr  <= '0;
                        state <= DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum   <= '0;
`endif
                    end
                    DATA: begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr;
                        wr_data <= rx_byte;
                        addr    <= addr + 1'b1;
                        left    <= left - 1'b1;
`ifdef PROG_LOADER_CHECKSUM_EN
                        sum     <= sum + rx_byte;
                        if (left == NW'(1)) state <= CSUM;
`else
                        if (left == NW'(1)) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_rstn <= 1'b1;
                        end
`endif
                    end
`ifdef PROG_LOADER_CHECKSUM_EN
                    CSUM: if (rx_byte == sum) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        cpu_rstn <= 1'b1;
                    end else begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed and random UART frames checked against a byte-level model of the loader.
// Adapts its expectations to whether PROG_LOADER_CHECKSUM_EN is defined.
module tb_prog_loader;
    localparam int CPB   = 4;
    localparam int DEPTH = 16;
    localparam int HDR   = 8'hA5;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int CSUM_ON = 1;
`else
    localparam int CSUM_ON = 0;
`endif

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rx = 1'b1;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       cpu_rstn, busy, done, err;

    int checks = 0, errors = 0;
    int cyc = 0, nwr = 0;
    int m_frame = 0, m_have_n = 0, m_left = 0, m_sum = 0, m_addr = 0, m_nwr = 0;
    int m_err = 0, m_done = 0, m_cpu = 0;
    int e_we = 0, e_addr = 0, e_data = 0;

    prog_loader #(
        .WIDTH        (8),
        .ADDRESS_WIDTH(4),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk     (clk),
        .rstn    (rstn),
        .rx      (rx),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cpu_rstn(cpu_rstn),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr_en) nwr <= nwr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outputs(input string ph, input int we);
        chk({ph, "_wr_en"}, 32'(wr_en), we);
        chk({ph, "_busy"}, 32'(busy), m_frame);
        chk({ph, "_err"}, 32'(err), m_err);
        chk({ph, "_done"}, 32'(done), m_done);
        chk({ph, "_cpu_rstn"}, 32'(cpu_rstn), m_cpu);
    endtask

    task automatic check_reset(input string ph);
        chk({ph, "_wr_en"}, 32'(wr_en), 0);
        chk({ph, "_wr_addr"}, 32'(wr_addr), 0);
        chk({ph, "_wr_data"}, 32'(wr_data), 0);
        chk({ph, "_cpu_rstn"}, 32'(cpu_rstn), 0);
        chk({ph, "_busy"}, 32'(busy), 0);
        chk({ph, "_done"}, 32'(done), 0);
        chk({ph, "_err"}, 32'(err), 0);
    endtask

    // Reference: what one received byte does to the loaded image and the status flags.
    task automatic model_byte(input int b);
        e_we = 0;
        if (m_frame == 0) begin
            if (b == HDR) begin
                m_frame = 1; m_have_n = 0; m_err = 0; m_done = 0; m_cpu = 0;
            end
        end else if (m_have_n == 0) begin
            m_left = (b == 0) ? DEPTH : b;
            if (m_left > DEPTH) begin
                m_err = 1; m_frame = 0;
            end else begin
                m_have_n = 1; m_addr = 0; m_sum = 0;
            end
        end else if (m_left > 0) begin
            e_we = 1; e_addr = m_addr; e_data = b; m_nwr++;
            m_addr = (m_addr + 1) % DEPTH;
            m_sum = (m_sum + b) % 256;
            m_left--;
            if (m_left == 0 && CSUM_ON == 0) begin
                m_frame = 0; m_done = 1; m_cpu = 1;
            end
        end else if (b == m_sum) begin
            m_frame = 0; m_done = 1; m_cpu = 1;
        end else begin
            m_err = 1; m_frame = 0;
        end
    endtask

    task automatic model_ferr();
        e_we = 0;
        if (m_frame != 0) begin
            m_err = 1; m_frame = 0;
        end
    endtask

    task automatic model_reset();
        m_frame = 0; m_have_n = 0; m_err = 0; m_done = 0; m_cpu = 0; e_we = 0;
    endtask

    // Outputs must hold on the cycle of rx_valid and change exactly one cycle later.
    task automatic send_byte(input logic [7:0] b, input bit stop);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("write_count", nwr, m_nwr);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check_outputs("pre", 0);
        if (stop) model_byte(int'(b));
        else model_ferr();
        @(negedge clk);
        check_outputs("post", e_we);
        if (e_we != 0) begin
            chk("wr_addr", 32'(wr_addr), e_addr);
            chk("wr_data", 32'(wr_data), e_data);
        end
    endtask

    task automatic send_seq(input bq_t q);
        foreach (q[i]) send_byte(q[i], 1'b1);
    endtask

    function automatic bq_t mk_frame(input int n, input bit bad_sum);
        bq_t q;
        int cnt, sum;
        logic [7:0] d;
        q = {8'hA5, 8'(n)};
        if (n > DEPTH) return q;
        cnt = (n == 0) ? DEPTH : n;
        sum = 0;
        for (int i = 0; i < cnt; i++) begin
            d = 8'($urandom_range(0, 255));
            q.push_back(d);
            sum = (sum + int'(d)) % 256;
        end
        if (CSUM_ON != 0) q.push_back(bad_sum ? 8'(sum) ^ 8'($urandom_range(1, 255)) : 8'(sum));
        return q;
    endfunction

    initial begin
        bq_t q;
        int k;
        logic [7:0] j;
        rstn = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rstn = 1'b1;
        repeat (500) @(negedge clk);
        check_reset("quiet");

        q = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
        send_seq(q);
        q = {8'hA5, 8'h02, 8'h01, 8'h02, 8'h00};
        send_seq(q);
        send_seq(mk_frame(3, 1'b0));
        q = {8'hA5, 8'h00};
        for (int i = 0; i < 16; i++) q.push_back(8'(i));
        q.push_back(8'h78);
        send_seq(q);
        q = {8'hA5, 8'h11};
        send_seq(q);

        q = {8'hA5, 8'h04, 8'h10};
        send_seq(q);
        @(negedge clk) rx = 1'b0;
        @(negedge clk) rx = 1'b1;
        repeat (12) @(negedge clk);
        check_outputs("glitch", 0);
        chk("glitch_writes", nwr, m_nwr);
        send_byte(8'h20, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);

        send_seq(mk_frame(2, 1'b0));
        send_byte(8'hFF, 1'b0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h5E, 1'b1);
        if (CSUM_ON != 0) send_byte(8'h5E, 1'b1);

        q = {8'hA5, 8'h05, 8'h01, 8'h02};
        send_seq(q);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_reset("async_rst");
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check_reset("post_rst");
        send_seq(mk_frame(4, 1'b0));

        for (int it = 0; it < 25; it++) begin
            k = $urandom_range(0, 9);
            if (k < 2) begin
                for (int b = 0; b < 2; b++) begin
                    do j = 8'($urandom_range(0, 255)); while (j == 8'hA5);
                    send_byte(j, 1'b1);
                end
            end else if (k < 4) send_seq(mk_frame($urandom_range(17, 255), 1'b0));
            else if (k < 6) send_seq(mk_frame($urandom_range(0, 16), 1'b1));
            else send_seq(mk_frame($urandom_range(0, 16), 1'b0));
        end

        repeat (10) @(negedge clk);
        chk("final_writes", nwr, m_nwr);
        check_outputs("final", 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
